// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x write-back slice: pipeline register, CSR opcodes,
// load-size encodings and the WB-stage state encoding.
package cv32e40x_pkg;

  typedef logic [4:0] rf_addr_t;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_opcode_e;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_type_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'b00,
    WB_WAIT = 2'b01,
    WB_DROP = 2'b10
  } wb_state_e;

  typedef struct packed {
    logic        instr_valid;
    logic        rf_we;
    rf_addr_t    rf_waddr;
    logic [31:0] rf_wdata;
    logic        data_req;
    logic        csr_en;
    csr_opcode_e csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } ex_wb_pipe_t;

endpackage

// File: rtl/cv32e40x_load_align.sv
// Combinational alignment and sign/zero extension of word-aligned load data.
module cv32e40x_load_align
  import cv32e40x_pkg::*;
(
  input  logic [1:0]  lsu_type_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [15:0] sh;

  always_comb begin
    sh = 16'(rdata_i >> {addr_lsb_i, 3'b000});
    case (lsu_type_e'(lsu_type_i))
      LSU_BYTE: rdata_o = {{24{sign_ext_i & sh[7]}}, sh[7:0]};
      LSU_HALF: rdata_o = {{16{sign_ext_i & sh[15]}}, sh[15:0]};
      default:  rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cv32e40x_wb_stage.sv
// Write-back stage: retires one instruction per cycle, holds loads until their
// response arrives, buffers responses under halt and drops responses of killed loads.
module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  ex_wb_pipe_t            ex_wb_pipe_i,
  input  logic [1:0]             lsu_type_i,
  input  logic                   lsu_sign_ext_i,
  input  logic [1:0]             lsu_addr_lsb_i,
  input  logic                   lsu_rvalid_i,
  input  logic [31:0]            lsu_rdata_i,
  input  logic                   lsu_err_i,
  input  logic                   halt_wb_i,
  input  logic                   kill_wb_i,
  output logic                   rf_we_wb_o,
  output rf_addr_t               rf_waddr_wb_o,
  output logic [31:0]            rf_wdata_wb_o,
  output logic                   csr_we_o,
  output logic                   wb_ready_o,
  output logic                   wb_valid_o,
  output logic                   lsu_err_o,
  input  logic                   cnt_clr_i,
  output logic [STALL_CNT_W-1:0] load_stall_cnt_o
);

  wb_state_e              state_q, state_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [31:0]            buf_rdata_q, buf_rdata_d;
  logic                   buf_err_q, buf_err_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic        iv;
  logic        data_req;
  logic        resp_av;
  logic [31:0] rdata_sel;
  logic        err_sel;
  logic        ld_err;
  logic        capture;
  logic [31:0] load_data;

  // CSR address/data are consumed by the CSR file, not by this stage.
  logic unused_pipe;
  assign unused_pipe = ^{ex_wb_pipe_i.csr_addr, ex_wb_pipe_i.csr_wdata};

  cv32e40x_load_align u_load_align (
    .lsu_type_i (lsu_type_i),
    .sign_ext_i (lsu_sign_ext_i),
    .addr_lsb_i (lsu_addr_lsb_i),
    .rdata_i    (rdata_sel),
    .rdata_o    (load_data)
  );

  always_comb begin
    iv        = ex_wb_pipe_i.instr_valid;
    data_req  = ex_wb_pipe_i.data_req;
    resp_av   = lsu_rvalid_i || buf_valid_q;
    rdata_sel = buf_valid_q ? buf_rdata_q : lsu_rdata_i;
    err_sel   = buf_valid_q ? buf_err_q : lsu_err_i;
    ld_err    = data_req && err_sel;

    wb_valid_o = iv && !halt_wb_i && !kill_wb_i && (state_q != WB_DROP) &&
                 (!data_req || resp_av);
    wb_ready_o = (!iv || wb_valid_o || kill_wb_i) && (state_q != WB_DROP);

    rf_we_wb_o    = wb_valid_o && ex_wb_pipe_i.rf_we && !ld_err;
    rf_waddr_wb_o = ex_wb_pipe_i.rf_waddr;
    rf_wdata_wb_o = data_req ? load_data : ex_wb_pipe_i.rf_wdata;
    csr_we_o      = wb_valid_o && ex_wb_pipe_i.csr_en &&
                    (ex_wb_pipe_i.csr_op != CSR_OP_READ);
    lsu_err_o     = wb_valid_o && ld_err;

    // A response is held only when it belongs to a live load that cannot retire now.
    capture = lsu_rvalid_i && !buf_valid_q && iv && data_req && !kill_wb_i &&
              !wb_valid_o && (state_q != WB_DROP);
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rdata_d = buf_rdata_q;
    buf_err_d   = buf_err_q;
    if (kill_wb_i || wb_valid_o) begin
      buf_valid_d = 1'b0;
    end else if (capture) begin
      buf_valid_d = 1'b1;
      buf_rdata_d = lsu_rdata_i;
      buf_err_d   = lsu_err_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (iv && data_req && !resp_av && !kill_wb_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (kill_wb_i) begin
          state_d = lsu_rvalid_i ? WB_IDLE : WB_DROP;
        end else if (wb_valid_o || lsu_rvalid_i) begin
          state_d = WB_IDLE;
        end
      end
      WB_DROP: begin
        if (lsu_rvalid_i) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if ((state_q == WB_WAIT) && !lsu_rvalid_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  assign load_stall_cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WB_IDLE;
      buf_valid_q <= 1'b0;
      buf_rdata_q <= '0;
      buf_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_rdata_q <= buf_rdata_d;
      buf_err_q   <= buf_err_d;
      cnt_q       <= cnt_d;
    end
  end

  rvalid_while_buffered: assert property (
    @(posedge clk) disable iff (!rst_n) !(lsu_rvalid_i && buf_valid_q)
  );

endmodule
